// File: rtl/daa_pkg.sv
// Shared types and flag positions for the serial decimal-adjust unit.
// Flag vector layout is [Z,N,H,C] at bits 3..0.
package daa_pkg;

    localparam int Z = 3;
    localparam int N = 2;
    localparam int H = 1;
    localparam int C = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } daa_state_t;

endpackage

// File: rtl/daa_digit_step.sv
// One-nibble decimal-adjust step: combinational, zero latency, no handshake.
// Chains the greater-than-nines bit and the nibble carry/borrow to the next digit.
module daa_digit_step (
    input  logic [3:0] d,
    input  logic       hc_i,
    input  logic       n,
    input  logic       gt_in,
    input  logic       nc_in,
    output logic [3:0] r,
    output logic       gt_out,
    output logic       nc_out,
    output logic       corr_flag
);

    logic [4:0] corr;
    logic [4:0] sum;

    always_comb begin
        gt_out    = (d > 4'd9) | ((d == 4'd9) & gt_in);
        corr_flag = hc_i | (~n & gt_out);
        corr      = corr_flag ? 5'd6 : 5'd0;
        // Bit 4 of the 5-bit result is the carry (add) or the borrow (subtract).
        if (n) begin
            sum = {1'b0, d} - corr - {4'b0000, nc_in};
        end else begin
            sum = {1'b0, d} + corr + {4'b0000, nc_in};
        end
        r      = sum[3:0];
        nc_out = sum[4];
    end

endmodule

// File: rtl/daa_serial.sv
// Multi-digit BCD decimal adjust, one digit per cycle; result valid DIGITS cycles after accept.
// in_ready only in IDLE; the result is held in DONE until out_ready.
module daa_serial
    import daa_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [DIGITS-1:0]     hc,
    input  logic                  n,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   daa,
    output logic [3:0]            fout
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    daa_state_t      state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [DIGITS-1:0] hc_q, hc_d;
    logic            n_q, n_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            gt_q, gt_d;
    logic            nc_q, nc_d;
    logic [W-1:0]    daa_q, daa_d;
    logic [3:0]      fout_q, fout_d;

    logic [3:0]      dig;
    logic            dig_hc;
    logic [3:0]      step_r;
    logic            step_gt;
    logic            step_nc;
    logic            step_corr;

    // Select the current digit and its carry bit by index.
    always_comb begin
        dig    = 4'h0;
        dig_hc = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                dig    = a_q[4*i +: 4];
                dig_hc = hc_q[i];
            end
        end
    end

    daa_digit_step u_step (
        .d         (dig),
        .hc_i      (dig_hc),
        .n         (n_q),
        .gt_in     (gt_q),
        .nc_in     (nc_q),
        .r         (step_r),
        .gt_out    (step_gt),
        .nc_out    (step_nc),
        .corr_flag (step_corr)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        hc_d    = hc_q;
        n_d     = n_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        nc_d    = nc_q;
        daa_d   = daa_q;
        fout_d  = fout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    hc_d    = hc;
                    n_d     = n;
                    idx_d   = '0;
                    gt_d    = 1'b0;
                    nc_d    = 1'b0;
                    daa_d   = '0;
                    fout_d  = 4'h0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IW'(i)) begin
                        daa_d[4*i +: 4] = step_r;
                    end
                end
                gt_d  = step_gt;
                nc_d  = step_nc;
                idx_d = idx_q + IW'(1);
                // The top digit's correction decision is exactly the decimal carry.
                if (idx_q == LAST) begin
                    fout_d[Z] = (daa_d == '0);
                    fout_d[N] = n_q;
                    fout_d[H] = 1'b0;
                    fout_d[C] = step_corr;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            hc_q    <= '0;
            n_q     <= 1'b0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            nc_q    <= 1'b0;
            daa_q   <= '0;
            fout_q  <= 4'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            hc_q    <= hc_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            gt_q    <= gt_d;
            nc_q    <= nc_d;
            daa_q   <= daa_d;
            fout_q  <= fout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign daa       = daa_q;
    assign fout      = fout_q;

endmodule
